// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage and the data memory.
// The stage is the master: it requests and the memory answers with a one-cycle ack.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results through, runs loads/stores
// over a req/ack bus with byte-lane formatting, and flags misaligned accesses
// and bus timeouts. mem_stall holds EX/MEM while a transaction is in flight.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_from_ex_mem,
  input  logic        write_reg_from_ex_mem,
  input  logic        read_mem_from_ex_mem,
  input  logic        write_mem_from_ex_mem,
  input  logic [2:0]  funct3_from_ex_mem,
  input  logic [31:0] result_from_ex_mem,
  input  logic [31:0] data_to_mem_from_ex_mem,
  mem_access_stage_if.master dmem,
  output logic        mem_stall,
  output logic [4:0]  rd_to_wb,
  output logic        write_reg_to_wb,
  output logic [31:0] wb_data_to_wb,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_lat_q, rd_lat_d;
  logic        wr_lat_q, wr_lat_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic        wr_wb_q, wr_wb_d;
  logic [31:0] wbd_q, wbd_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  logic        is_mem;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] load_data;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  // funct3[1] set means word (including the unused 011/110/111 codes); else funct3[0] selects half
  assign is_mem      = read_mem_from_ex_mem | write_mem_from_ex_mem;
  assign misaligned  = funct3_from_ex_mem[1] ? (|result_from_ex_mem[1:0])
                                             : (funct3_from_ex_mem[0] & result_from_ex_mem[0]);
  assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Store lane formatting: replicate data across lanes, enable only the addressed bytes
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = data_to_mem_from_ex_mem;
    if (!funct3_from_ex_mem[1]) begin
      if (funct3_from_ex_mem[0]) begin
        be_fmt    = 4'b0011 << result_from_ex_mem[1:0];
        wdata_fmt = {2{data_to_mem_from_ex_mem[15:0]}};
      end else begin
        be_fmt    = 4'b0001 << result_from_ex_mem[1:0];
        wdata_fmt = {4{data_to_mem_from_ex_mem[7:0]}};
      end
    end
  end

  // Load lane extraction and sign/zero extension from the latched access shape
  always_comb begin
    lbyte     = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
    lhalf     = dmem.dmem_rdata[{off_q[1], 4'b0000} +: 16];
    load_data = dmem.dmem_rdata;
    if (!f3_q[1]) begin
      if (f3_q[0]) load_data = {{16{~f3_q[2] & lhalf[15]}}, lhalf};
      else         load_data = {{24{~f3_q[2] & lbyte[7]}}, lbyte};
    end
  end

  // Next-state, bus and writeback logic; pulses default low every cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    off_d     = off_q;
    rd_lat_d  = rd_lat_q;
    wr_lat_d  = wr_lat_q;
    rd_wb_d   = rd_wb_q;
    wr_wb_d   = wr_wb_q;
    wbd_d     = wbd_q;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (!is_mem) begin
          rd_wb_d = rd_from_ex_mem;
          wr_wb_d = write_reg_from_ex_mem;
          wbd_d   = result_from_ex_mem;
        end else if (misaligned) begin
          mis_d   = 1'b1;
          rd_wb_d = rd_from_ex_mem;
          wr_wb_d = 1'b0;
          wbd_d   = result_from_ex_mem;
        end else begin
          mem_stall = 1'b1;
          wr_wb_d   = 1'b0;
          req_d     = 1'b1;
          we_d      = write_mem_from_ex_mem;
          addr_d    = {result_from_ex_mem[31:2], 2'b00};
          be_d      = be_fmt;
          wdata_d   = wdata_fmt;
          f3_d      = funct3_from_ex_mem;
          off_d     = result_from_ex_mem[1:0];
          rd_lat_d  = rd_from_ex_mem;
          wr_lat_d  = write_reg_from_ex_mem;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
          rd_wb_d = rd_lat_q;
          if (we_q) begin
            wr_wb_d = 1'b0;
          end else begin
            wr_wb_d = wr_lat_q;
            wbd_d   = load_data;
          end
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          wr_wb_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          mem_stall = 1'b1;
          wr_wb_d   = 1'b0;
          cnt_d     = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      off_q    <= '0;
      rd_lat_q <= '0;
      wr_lat_q <= 1'b0;
      rd_wb_q  <= '0;
      wr_wb_q  <= 1'b0;
      wbd_q    <= '0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rd_lat_q <= rd_lat_d;
      wr_lat_q <= wr_lat_d;
      rd_wb_q  <= rd_wb_d;
      wr_wb_q  <= wr_wb_d;
      wbd_q    <= wbd_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign rd_to_wb        = rd_wb_q;
  assign write_reg_to_wb = wr_wb_q;
  assign wb_data_to_wb   = wbd_q;
  assign misalign_exc    = mis_q;
  assign bus_err         = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// instructions checked against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rd_in = '0;
  logic        wreg_in = 1'b0;
  logic        rmem_in = 1'b0;
  logic        wmem_in = 1'b0;
  logic [2:0]  f3_in = '0;
  logic [31:0] res_in = '0;
  logic [31:0] data_in = '0;
  logic        mem_stall;
  logic [4:0]  rd_to_wb;
  logic        write_reg_to_wb;
  logic [31:0] wb_data_to_wb;
  logic        misalign_exc;
  logic        bus_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .rd_from_ex_mem          (rd_in),
    .write_reg_from_ex_mem   (wreg_in),
    .read_mem_from_ex_mem    (rmem_in),
    .write_mem_from_ex_mem   (wmem_in),
    .funct3_from_ex_mem      (f3_in),
    .result_from_ex_mem      (res_in),
    .data_to_mem_from_ex_mem (data_in),
    .dmem                    (bus.master),
    .mem_stall               (mem_stall),
    .rd_to_wb                (rd_to_wb),
    .write_reg_to_wb         (write_reg_to_wb),
    .wb_data_to_wb           (wb_data_to_wb),
    .misalign_exc            (misalign_exc),
    .bus_err                 (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width in bytes from funct3
  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = acc_size(f3);
    if (s == 4) return 32'd15;
    return ((32'd1 << s) - 32'd1) << (a % 4);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (acc_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] v;
    int unsigned sh = 8 * (a % 4);
    case (acc_size(f3))
      1: begin
        v = (rdata >> sh) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      2: begin
        v = (rdata >> sh) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  // Issue one instruction and follow it to completion; delay = BUSY cycles before ack
  task automatic run_op(input logic [4:0] rd, input logic wreg, input logic rmem, input logic wmem,
                        input logic [2:0] f3, input logic [31:0] res, input logic [31:0] data,
                        input int unsigned delay, input logic [31:0] rdata, input logic idle_ack);
    bit done;
    rd_in = rd; wreg_in = wreg; rmem_in = rmem; wmem_in = wmem;
    f3_in = f3; res_in = res; data_in = data;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = $urandom;
    if (!(rmem || wmem)) begin
      bus.dmem_ack = idle_ack;
      #1 check("alu_stall", {31'd0, mem_stall}, 32'd0);
      tick();
      bus.dmem_ack = 1'b0;
      check("alu_rd", {27'd0, rd_to_wb}, {27'd0, rd});
      check("alu_wreg", {31'd0, write_reg_to_wb}, {31'd0, wreg});
      check("alu_data", wb_data_to_wb, res);
      check("alu_mis", {31'd0, misalign_exc}, 32'd0);
      check("alu_berr", {31'd0, bus_err}, 32'd0);
      check("alu_req", {31'd0, bus.dmem_req}, 32'd0);
    end else if (is_misaligned(f3, res)) begin
      #1 check("mis_stall", {31'd0, mem_stall}, 32'd0);
      tick();
      check("mis_exc", {31'd0, misalign_exc}, 32'd1);
      check("mis_wreg", {31'd0, write_reg_to_wb}, 32'd0);
      check("mis_req", {31'd0, bus.dmem_req}, 32'd0);
    end else begin
      #1 check("mem_entry_stall", {31'd0, mem_stall}, 32'd1);
      tick();
      check("mem_entry_mis", {31'd0, misalign_exc}, 32'd0);
      check("mem_entry_berr", {31'd0, bus_err}, 32'd0);
      done = 1'b0;
      for (int unsigned i = 0; i < TO && !done; i++) begin
        check("busy_req", {31'd0, bus.dmem_req}, 32'd1);
        check("busy_we", {31'd0, bus.dmem_we}, {31'd0, wmem});
        check("busy_addr", bus.dmem_addr, res & 32'hFFFF_FFFC);
        check("busy_be", {28'd0, bus.dmem_be}, exp_be(f3, res));
        if (wmem) check("busy_wdata", bus.dmem_wdata, exp_wdata(f3, data));
        check("busy_wreg", {31'd0, write_reg_to_wb}, 32'd0);
        if (i == delay) begin
          bus.dmem_ack = 1'b1;
          bus.dmem_rdata = rdata;
          #1 check("ack_stall", {31'd0, mem_stall}, 32'd0);
          tick();
          bus.dmem_ack = 1'b0;
          check("done_req", {31'd0, bus.dmem_req}, 32'd0);
          check("done_berr", {31'd0, bus_err}, 32'd0);
          if (wmem) begin
            check("st_wreg", {31'd0, write_reg_to_wb}, 32'd0);
          end else begin
            check("ld_wreg", {31'd0, write_reg_to_wb}, {31'd0, wreg});
            check("ld_rd", {27'd0, rd_to_wb}, {27'd0, rd});
            check("ld_data", wb_data_to_wb, exp_load(f3, res, rdata));
          end
          done = 1'b1;
        end else if (i == TO - 1) begin
          #1 check("to_stall", {31'd0, mem_stall}, 32'd0);
          tick();
          check("to_req", {31'd0, bus.dmem_req}, 32'd0);
          check("to_berr", {31'd0, bus_err}, 32'd1);
          check("to_wreg", {31'd0, write_reg_to_wb}, 32'd0);
          done = 1'b1;
        end else begin
          #1 check("busy_stall", {31'd0, mem_stall}, 32'd1);
          tick();
        end
      end
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int unsigned kind;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("rst_addr", bus.dmem_addr, 32'd0);
    check("rst_wreg", {31'd0, write_reg_to_wb}, 32'd0);
    check("rst_data", wb_data_to_wb, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);

    // Directed cases
    run_op(5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 0, 32'd0, 1'b0);
    run_op(5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 3, 32'h80FF_FF00, 1'b0);
    run_op(5'd7, 1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 3, 32'h80FF_FF00, 1'b0);
    run_op(5'd3, 1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hAAAA_BEEF, 0, 32'd0, 1'b0);
    run_op(5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 0, 32'd0, 1'b0);
    run_op(5'd6, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_00AA, 32'd0, 0, 32'd0, 1'b0);
    run_op(5'd8, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'd0, 99, 32'd0, 1'b0);
    run_op(5'd9, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'd0, 0, 32'hDEAD_BEEF, 1'b1);

    // Reset in the second BUSY cycle abandons the load
    rd_in = 5'd10; wreg_in = 1'b1; rmem_in = 1'b1; wmem_in = 1'b0;
    f3_in = 3'b010; res_in = 32'h0000_4000;
    #1 check("rb_entry_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    check("rb_busy1_req", {31'd0, bus.dmem_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rb_req", {31'd0, bus.dmem_req}, 32'd0);
    check("rb_be", {28'd0, bus.dmem_be}, 32'd0);
    check("rb_wreg", {31'd0, write_reg_to_wb}, 32'd0);
    check("rb_data", wb_data_to_wb, 32'd0);
    check("rb_berr", {31'd0, bus_err}, 32'd0);
    run_op(5'd11, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_7777, 32'd0, 0, 32'd0, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      if (kind < 4) begin
        run_op(5'($urandom), 1'($urandom), 1'b0, 1'b0, f3, a, $urandom, 0, 32'd0, 1'($urandom));
      end else begin
        run_op(5'($urandom), 1'($urandom), 1'($urandom_range(0, 1) | (kind < 7 ? 1 : 0)),
               (kind >= 7) ? 1'b1 : 1'($urandom_range(0, 3) == 0),
               f3, a, $urandom, $urandom_range(0, 5), $urandom, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
